// File: rtl/window_scheduler_if.sv
// Window handler / correlator link of the window scheduler: fill-phase
// address path, handler kick and patch handshake, and the score stream.
interface window_scheduler_if #(
    parameter int ADDR_W  = 20,
    parameter int SCORE_W = 24
);
    logic [ADDR_W-1:0]  mem_addr;
    logic               wh_en;
    logic               wh_ack;
    logic [6:0]         wh_row;
    logic [6:0]         wh_col;
    logic               wh_window_ready;
    logic               wh_done;
    logic               wh_receive;
    logic               score_valid;
    logic [SCORE_W-1:0] score;

    // Scheduler side
    modport master (
        output mem_addr, wh_en, wh_receive,
        input  wh_ack, wh_row, wh_col, wh_window_ready, wh_done, score_valid, score
    );

    // Handler / correlator side
    modport slave (
        input  mem_addr, wh_en, wh_receive,
        output wh_ack, wh_row, wh_col, wh_window_ready, wh_done, score_valid, score
    );
endinterface

// File: rtl/window_scheduler.sv
// Tile-level sequencer for the 80x80 search-window handler. Walks the frame
// tile by tile: generates fill addresses, kicks the handler, counts the 65x65
// streamed patches, tracks the minimum correlator score and reports it.
module window_scheduler #(
    parameter int IMG_W_WORDS = 160,
    parameter int TILES_X     = 8,
    parameter int TILES_Y     = 6,
    parameter int ADDR_W      = 20,
    parameter int SCORE_W     = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               busy,
    output logic               frame_done,
    window_scheduler_if.master bus,
    output logic               result_valid,
    output logic [2:0]         tile_x,
    output logic [2:0]         tile_y,
    output logic [SCORE_W-1:0] best_score,
    output logic [6:0]         best_dx,
    output logic [6:0]         best_dy,
    output logic               err
);

    localparam logic [12:0]       NPATCH     = 13'd4225;   // 65 x 65 patches per tile
    localparam logic [6:0]        LAST_OFS   = 7'd64;
    localparam logic [ADDR_W-1:0] PITCH      = ADDR_W'(IMG_W_WORDS);
    localparam logic [ADDR_W-1:0] TILE_ROWS  = ADDR_W'(80);
    localparam logic [ADDR_W-1:0] TILE_WORDS = ADDR_W'(20);
    localparam logic [2:0]        LAST_TX    = 3'(TILES_X - 1);
    localparam logic [2:0]        LAST_TY    = 3'(TILES_Y - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KICK   = 3'd1,
        FILL   = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        REPORT = 3'd5
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base;
    logic [6:0]         px;
    logic [6:0]         py;
    logic [6:0]         sx;
    logic [6:0]         sy;
    logic [12:0]        patch_cnt;
    logic [12:0]        score_cnt;

    logic [ADDR_W-1:0]  row_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [12:0]        patch_cnt_next_s;
    logic               patch_phase_s;

    // Fill address and patch acknowledge follow the handler combinationally
    always_comb begin
        row_s            = ADDR_W'(tile_y) * TILE_ROWS + ADDR_W'(bus.wh_row);
        addr_s           = base + row_s * PITCH + ADDR_W'(tile_x) * TILE_WORDS
                           + ADDR_W'(bus.wh_col);
        patch_phase_s    = (state == FILL) || (state == STREAM);
        patch_cnt_next_s = patch_cnt + {12'd0, bus.wh_window_ready};
        if (state == FILL) begin
            bus.mem_addr = addr_s;
        end else begin
            bus.mem_addr = {ADDR_W{1'b0}};
        end
        if (patch_phase_s) begin
            bus.wh_receive = bus.wh_window_ready;
        end else begin
            bus.wh_receive = 1'b0;
        end
    end

    // Tile sequencing FSM, patch/score counters and best-score tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            base         <= {ADDR_W{1'b0}};
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            bus.wh_en    <= 1'b0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            tile_x       <= 3'd0;
            tile_y       <= 3'd0;
            best_score   <= {SCORE_W{1'b1}};
            best_dx      <= 7'd0;
            best_dy      <= 7'd0;
            px           <= 7'd0;
            py           <= 7'd0;
            sx           <= 7'd0;
            sy           <= 7'd0;
            patch_cnt    <= 13'd0;
            score_cnt    <= 13'd0;
        end else begin
            result_valid <= 1'b0;
            frame_done   <= 1'b0;

            // Patches are counted on every handler presentation, including
            // the one that ends FILL.
            if (patch_phase_s && bus.wh_window_ready) begin
                patch_cnt <= patch_cnt_next_s;
                if (px == LAST_OFS) begin
                    px <= 7'd0;
                    py <= py + 7'd1;
                end else begin
                    px <= px + 7'd1;
                end
            end

            case (state)
                IDLE: begin
                    // busy covers the frame_done cycle; a start there is ignored
                    if (frame_done) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        base      <= base_addr;
                        tile_x    <= 3'd0;
                        tile_y    <= 3'd0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        bus.wh_en <= 1'b1;
                        state     <= KICK;
                    end
                end
                KICK: begin
                    if (bus.wh_ack) begin
                        bus.wh_en  <= 1'b0;
                        best_score <= {SCORE_W{1'b1}};
                        best_dx    <= 7'd0;
                        best_dy    <= 7'd0;
                        px         <= 7'd0;
                        py         <= 7'd0;
                        sx         <= 7'd0;
                        sy         <= 7'd0;
                        patch_cnt  <= 13'd0;
                        score_cnt  <= 13'd0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (bus.wh_window_ready) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.wh_done) begin
                        if (patch_cnt_next_s != NPATCH) begin
                            err <= 1'b1;
                        end
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (score_cnt == NPATCH) begin
                        result_valid <= 1'b1;
                        state        <= REPORT;
                    end
                end
                REPORT: begin
                    if (tile_x == LAST_TX) begin
                        tile_x <= 3'd0;
                        if (tile_y == LAST_TY) begin
                            tile_y     <= 3'd0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            tile_y    <= tile_y + 3'd1;
                            bus.wh_en <= 1'b1;
                            state     <= KICK;
                        end
                    end else begin
                        tile_x    <= tile_x + 3'd1;
                        bus.wh_en <= 1'b1;
                        state     <= KICK;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Scores arrive in patch order; a strict compare keeps the
            // earliest of equal minima. Stray scores only flag err.
            if (bus.score_valid) begin
                if ((state == STREAM) || (state == DRAIN)) begin
                    if (score_cnt == NPATCH) begin
                        err <= 1'b1;
                    end else begin
                        if (bus.score < best_score) begin
                            best_score <= bus.score;
                            best_dx    <= sx;
                            best_dy    <= sy;
                        end
                        score_cnt <= score_cnt + 13'd1;
                        if (sx == LAST_OFS) begin
                            sx <= 7'd0;
                            sy <= sy + 7'd1;
                        end else begin
                            sx <= sx + 7'd1;
                        end
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_scheduler.sv
// Directed bench for window_scheduler on a 3x2-tile frame. A behavioural
// handler/correlator feeds 4225 patches per tile (one per cycle) with scores
// returned 5 cycles later; per-tile expected results are hand-computed.
module tb_window_scheduler;

    localparam int ADDR_W  = 20;
    localparam int SCORE_W = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  base_addr;
    logic               busy;
    logic               frame_done;
    logic               result_valid;
    logic [2:0]         tile_x;
    logic [2:0]         tile_y;
    logic [SCORE_W-1:0] best_score;
    logic [6:0]         best_dx;
    logic [6:0]         best_dy;
    logic               err;

    int n_cmp = 0;
    int n_mis = 0;

    window_scheduler_if #(.ADDR_W(ADDR_W), .SCORE_W(SCORE_W)) bus_if ();

    window_scheduler #(
        .IMG_W_WORDS (160),
        .TILES_X     (3),
        .TILES_Y     (2),
        .ADDR_W      (ADDR_W),
        .SCORE_W     (SCORE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .busy         (busy),
        .frame_done   (frame_done),
        .bus          (bus_if.master),
        .result_valid (result_valid),
        .tile_x       (tile_x),
        .tile_y       (tile_y),
        .best_score   (best_score),
        .best_dx      (best_dx),
        .best_dy      (best_dy),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Hand-computed per-tile expectations (base 0x100, wh_row=3, wh_col=5)
    logic [31:0] exp_addr  [6] = '{32'd741, 32'd761, 32'd781, 32'd13541, 32'd13561, 32'h350D};
    logic [31:0] exp_best  [6] = '{32'd500, 32'd2000, 32'd5776, 32'd777, 32'd42, 32'd0};
    logic [31:0] exp_dx    [6] = '{32'd0, 32'd0, 32'd64, 32'd0, 32'd0, 32'd64};
    logic [31:0] exp_dy    [6] = '{32'd2, 32'd0, 32'd64, 32'd0, 32'd64, 32'd0};
    logic [31:0] exp_err   [6] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [SCORE_W-1:0] score_of(input int t, input int idx);
        case (t)
            0:       return ((idx == 130) || (idx == 200)) ? 24'd500 : 24'd1000;
            1:       return 24'(2000 + idx);
            2:       return 24'(10000 - idx);
            3:       return 24'd777;
            4:       return (idx == 4160) ? 24'd42 : 24'd3000;
            default: return (idx == 64) ? 24'd0 : 24'hFFFFFF;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_handler();
        bus_if.wh_ack          = 1'b0;
        bus_if.wh_window_ready = 1'b0;
        bus_if.wh_done         = 1'b0;
        bus_if.score_valid     = 1'b0;
        bus_if.score           = 24'd0;
    endtask

    task automatic run_tile(input int t);
        int  k;
        bit  seen;
        seen = 1'b0;
        for (k = 0; k < 20; k++) begin
            if (bus_if.wh_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("wh_en_seen", 32'(seen), 32'd1);
        bus_if.wh_ack = 1'b1;
        tick();
        bus_if.wh_ack = 1'b0;
        check_eq("wh_en_drop", 32'(bus_if.wh_en), 32'd0);
        bus_if.wh_row = 7'd3;
        bus_if.wh_col = 7'd5;
        #1;
        check_eq("fill_addr", 32'(bus_if.mem_addr), exp_addr[t]);
        check_eq("recv_idle", 32'(bus_if.wh_receive), 32'd0);
        tick();
        for (int c = 0; c <= 4230; c++) begin
            bus_if.wh_window_ready = (c < 4225);
            bus_if.wh_done         = (c == 4225);
            bus_if.score_valid     = ((c >= 5) && (c < 4230)) || ((t == 1) && (c == 4230));
            bus_if.score           = (c >= 5 && c < 4230) ? score_of(t, c - 5) : 24'd1;
            if ((t == 1) && (c == 100)) begin
                start     = 1'b1;
                base_addr = 20'h00999;
            end else begin
                start     = 1'b0;
            end
            if (c == 10) begin
                #1;
                check_eq("wh_receive", 32'(bus_if.wh_receive), 32'd1);
            end
            tick();
        end
        clear_handler();
        seen = 1'b0;
        for (k = 0; k < 20; k++) begin
            if (result_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("result_seen", 32'(seen), 32'd1);
        check_eq("tile_x", 32'(tile_x), 32'(t % 3));
        check_eq("tile_y", 32'(tile_y), 32'(t / 3));
        check_eq("best_score", 32'(best_score), exp_best[t]);
        check_eq("best_dx", 32'(best_dx), exp_dx[t]);
        check_eq("best_dy", 32'(best_dy), exp_dy[t]);
        check_eq("err_at_result", 32'(err), exp_err[t]);
        check_eq("busy_at_result", 32'(busy), 32'd1);
        tick();
        check_eq("result_one_cycle", 32'(result_valid), 32'd0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        base_addr     = 20'h00000;
        bus_if.wh_row = 7'd0;
        bus_if.wh_col = 7'd0;
        clear_handler();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_wh_en", 32'(bus_if.wh_en), 32'd0);
        check_eq("rst_result_valid", 32'(result_valid), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_tile", 32'({tile_y, tile_x}), 32'd0);
        check_eq("rst_best_score", 32'(best_score), 32'hFFFFFF);
        check_eq("rst_best_ofs", 32'({best_dy, best_dx}), 32'd0);
        check_eq("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);

        // Frame 1: 6 tiles from base 0x100
        start     = 1'b1;
        base_addr = 20'h00100;
        tick();
        start = 1'b0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_wh_en", 32'(bus_if.wh_en), 32'd1);
        for (int t = 0; t < 6; t++) begin
            run_tile(t);
        end
        check_eq("frame_done_pulse", 32'(frame_done), 32'd1);
        check_eq("busy_in_done", 32'(busy), 32'd1);
        tick();
        check_eq("frame_done_clear", 32'(frame_done), 32'd0);
        check_eq("busy_after_frame", 32'(busy), 32'd0);
        check_eq("err_sticky", 32'(err), 32'd1);
        check_eq("tile_wrapped", 32'({tile_y, tile_x}), 32'd0);

        // Frame 2: start clears err, then reset in the middle of STREAM
        start     = 1'b1;
        base_addr = 20'h00000;
        tick();
        start = 1'b0;
        check_eq("err_cleared", 32'(err), 32'd0);
        check_eq("restart_wh_en", 32'(bus_if.wh_en), 32'd1);
        bus_if.wh_ack = 1'b1;
        tick();
        bus_if.wh_ack = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus_if.wh_window_ready = 1'b1;
            bus_if.score_valid     = (c >= 1);
            bus_if.score           = 24'd5;
            tick();
        end
        clear_handler();
        check_eq("pre_rst_best", 32'(best_score), 32'd5);
        check_eq("pre_rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_best", 32'(best_score), 32'hFFFFFF);
        check_eq("mid_rst_wh_en", 32'(bus_if.wh_en), 32'd0);
        check_eq("mid_rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
        tick();
        check_eq("idle_after_rst", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
